// File: rtl/rv32_dec_pkg.sv
// RV32I decode: shared type codes, opcodes and control-word layout.
package rv32_dec_pkg;

    localparam int CWORD_W = 23;

    // Control-word field positions: {rs2, rs1, rd, fun7, fun3, type}
    localparam int CW_TYPE_LSB = 0;
    localparam int CW_FUN3_LSB = 4;
    localparam int CW_FUN7_BIT = 7;
    localparam int CW_RD_LSB   = 8;
    localparam int CW_RS1_LSB  = 13;
    localparam int CW_RS2_LSB  = 18;

    typedef enum logic [3:0] {
        T_LOAD    = 4'd0,
        T_IMM     = 4'd1,
        T_STORE   = 4'd2,
        T_REG     = 4'd3,
        T_LUI     = 4'd4,
        T_AUIPC   = 4'd5,
        T_BRANCH  = 4'd6,
        T_JALR    = 4'd7,
        T_JAL     = 4'd8,
        T_SYS     = 4'd9,
        T_ILLEGAL = 4'd15
    } itype_e;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // Assemble the control word from a raw instruction and its final type.
    function automatic logic [CWORD_W-1:0] pack_cword(input logic [31:0] inst,
                                                      input itype_e    t);
        pack_cword = {inst[24:20], inst[19:15], inst[11:7], inst[30], inst[14:12], t};
    endfunction

endpackage

// File: rtl/instr_dec_core.sv
// Combinational RV32I decode: type, fields, immediate, illegal flag.
module instr_dec_core
    import rv32_dec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_SYS = 1'b1
) (
    input  logic [31:0]         i_inst,
    output logic [CWORD_W-1:0]  o_cword,
    output logic [XLEN-1:0]     o_imm,
    output logic                o_illegal
);

    logic [6:0]         w_op;
    logic [2:0]         w_fun3;
    itype_e             w_base;
    itype_e             w_type;
    logic               w_bad;
    logic signed [31:0] w_imm32;

    assign w_op   = i_inst[6:0];
    assign w_fun3 = i_inst[14:12];

    // Opcode to base type, then reject encodings that are reserved within a type
    always_comb begin
        w_base = T_ILLEGAL;
        case (w_op)
            OP_LOAD:     w_base = T_LOAD;
            OP_IMM:      w_base = T_IMM;
            OP_STORE:    w_base = T_STORE;
            OP_REG:      w_base = T_REG;
            OP_LUI:      w_base = T_LUI;
            OP_AUIPC:    w_base = T_AUIPC;
            OP_BRANCH:   w_base = T_BRANCH;
            OP_JALR:     w_base = T_JALR;
            OP_JAL:      w_base = T_JAL;
            OP_MISC_MEM,
            OP_SYSTEM:   w_base = EN_SYS ? T_SYS : T_ILLEGAL;
            default:     w_base = T_ILLEGAL;
        endcase

        w_bad = (i_inst[1:0] != 2'b11);
        case (w_base)
            T_JALR:   if (w_fun3 != 3'b000) w_bad = 1'b1;
            T_BRANCH: if (w_fun3 == 3'b010 || w_fun3 == 3'b011) w_bad = 1'b1;
            T_LOAD:   if (w_fun3 == 3'b011 || w_fun3 == 3'b110 || w_fun3 == 3'b111) w_bad = 1'b1;
            T_STORE:  if (w_fun3 > 3'b010) w_bad = 1'b1;
            T_REG: begin
                if (i_inst[31:25] != 7'b0000000 && i_inst[31:25] != 7'b0100000) w_bad = 1'b1;
                // bit 30 only distinguishes SUB and SRA
                if (i_inst[30] && w_fun3 != 3'b000 && w_fun3 != 3'b101) w_bad = 1'b1;
            end
            default: ;
        endcase

        w_type = w_bad ? T_ILLEGAL : w_base;
    end

    // Immediate selected by the final type, so illegal words always carry zero
    always_comb begin
        w_imm32 = '0;
        case (w_type)
            T_LOAD, T_IMM, T_JALR, T_SYS:
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            T_STORE:
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            T_BRANCH:
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
            T_LUI, T_AUIPC:
                w_imm32 = {i_inst[31:12], 12'b0};
            T_JAL:
                w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    assign o_cword   = pack_cword(i_inst, w_type);
    assign o_imm     = XLEN'(w_imm32);
    assign o_illegal = (w_type == T_ILLEGAL);

endmodule

// File: rtl/instr_dec_stage.sv
// Registered RV32I decode stage with valid/ready, optional skid entry and flush.
module instr_dec_stage
    import rv32_dec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit SKID   = 1'b1,
    parameter bit EN_SYS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CWORD_W-1:0]  out_cword,
    output logic [XLEN-1:0]     out_imm,
    output logic [XLEN-1:0]     out_pc,
    output logic                out_illegal
);

    logic [CWORD_W-1:0] w_cword;
    logic [XLEN-1:0]    w_imm;
    logic               w_illegal;
    logic               w_in_xfer;
    logic               w_out_xfer;

    logic               r_out_valid;
    logic [CWORD_W-1:0] r_out_cword;
    logic [XLEN-1:0]    r_out_imm;
    logic [XLEN-1:0]    r_out_pc;
    logic               r_out_ill;

    instr_dec_core #(.XLEN(XLEN), .EN_SYS(EN_SYS)) u_core (
        .i_inst    (in_inst),
        .o_cword   (w_cword),
        .o_imm     (w_imm),
        .o_illegal (w_illegal)
    );

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            logic               r_skid_full;
            logic [CWORD_W-1:0] r_skid_cword;
            logic [XLEN-1:0]    r_skid_imm;
            logic [XLEN-1:0]    r_skid_pc;
            logic               r_skid_ill;
            logic               r_in_ready;

            // in_ready mirrors !skid_full but lives in its own flop so it has no comb path
            assign in_ready = r_in_ready;

            // Output register refills from skid first, then from the decoder; skid catches stalls
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid  <= 1'b0;
                    r_out_cword  <= '0;
                    r_out_imm    <= '0;
                    r_out_pc     <= '0;
                    r_out_ill    <= 1'b0;
                    r_skid_full  <= 1'b0;
                    r_skid_cword <= '0;
                    r_skid_imm   <= '0;
                    r_skid_pc    <= '0;
                    r_skid_ill   <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                    r_skid_full <= 1'b0;
                    r_in_ready  <= 1'b1;
                end else if (w_out_xfer || !r_out_valid) begin
                    if (r_skid_full) begin
                        // skid full implies in_ready=0, so no new input competes here
                        r_out_valid <= 1'b1;
                        r_out_cword <= r_skid_cword;
                        r_out_imm   <= r_skid_imm;
                        r_out_pc    <= r_skid_pc;
                        r_out_ill   <= r_skid_ill;
                        r_skid_full <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else if (w_in_xfer) begin
                        r_out_valid <= 1'b1;
                        r_out_cword <= w_cword;
                        r_out_imm   <= w_imm;
                        r_out_pc    <= in_pc;
                        r_out_ill   <= w_illegal;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end else if (w_in_xfer) begin
                    r_skid_full  <= 1'b1;
                    r_skid_cword <= w_cword;
                    r_skid_imm   <= w_imm;
                    r_skid_pc    <= in_pc;
                    r_skid_ill   <= w_illegal;
                    r_in_ready   <= 1'b0;
                end
            end
        end else begin : g_noskid
            assign in_ready = !r_out_valid | out_ready;

            // Single pipeline register: load on input transfer, empty on drain
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_out_cword <= '0;
                    r_out_imm   <= '0;
                    r_out_pc    <= '0;
                    r_out_ill   <= 1'b0;
                end else if (flush) begin
                    r_out_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_out_valid <= 1'b1;
                    r_out_cword <= w_cword;
                    r_out_imm   <= w_imm;
                    r_out_pc    <= in_pc;
                    r_out_ill   <= w_illegal;
                end else if (w_out_xfer) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid   = r_out_valid;
    assign out_cword   = r_out_cword;
    assign out_imm     = r_out_imm;
    assign out_pc      = r_out_pc;
    assign out_illegal = r_out_ill;

endmodule
